hidden_layer_scheduler: RTL and testbench

// - Time-multiplexes one shared 4-input neuron MAC datapath across all hidden-layer neurons (default 4).
// - Latches one input vector and issues the neuron once per weight column.
// - Collects each result into an output vector, then presents that vector downstream with valid/ready.
// - Sits between the input-vector source and the output layer. It replaces four parallel neurons with one neuron plus sequencing.

---
 rtl/dnn_pkg.sv | 22 ++
 rtl/sched_wait_timer.sv | 26 ++
 rtl/hidden_layer_scheduler.sv | 130 +++++++++++++
 tb/tb_hidden_layer_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared types and defaults for the hidden-layer scheduler: FSM state encoding,
// default datapath widths and the ReLU helper used by the optional clamp build.
package dnn_pkg;

  localparam int DNN_IN_W  = 5;
  localparam int DNN_W_W   = 5;
  localparam int DNN_OUT_W = 12;
  localparam int DNN_N_IN  = 4;
  localparam int DNN_N_NEU = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  function automatic logic signed [DNN_OUT_W-1:0] relu(input logic signed [DNN_OUT_W-1:0] x);
    return x[DNN_OUT_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/sched_wait_timer.sv
// Counts cycles spent waiting on the shared neuron; expired flags the last
// permitted wait cycle so the FSM can abort on the same edge.
module sched_wait_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CW'(1);
  end

  // Fires while the count-th idle cycle is the TIMEOUT_CYC-th one.
  assign expired = enable && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/hidden_layer_scheduler.sv
// Shares one 4-input neuron MAC across N_NEU hidden neurons and returns the result vector.
// Build option: define HIDDEN_LAYER_SCHED_RELU_EN to clamp negative neuron results to 0.
//   state | meaning
//   IDLE  | ready for a new input vector
//   ISSUE | pulse nrn_start for neuron idx
//   WAIT  | wait for nrn_done or timeout
//   DONE  | present out_vec until out_ready
module hidden_layer_scheduler
  import dnn_pkg::*;
#(
  parameter int IN_W        = DNN_IN_W,
  parameter int W_W         = DNN_W_W,
  parameter int OUT_W       = DNN_OUT_W,
  parameter int N_IN        = DNN_N_IN,
  parameter int N_NEU       = DNN_N_NEU,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_IN*IN_W-1:0]        in_vec,
  input  logic [N_NEU*N_IN*W_W-1:0]   weights,
  output logic                        nrn_start,
  output logic [N_IN*IN_W-1:0]        nrn_in,
  output logic [N_IN*W_W-1:0]         nrn_w,
  input  logic                        nrn_done,
  input  logic [OUT_W-1:0]            nrn_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_NEU*OUT_W-1:0]      out_vec,
  output logic                        err_timeout
);

  localparam int IDX_W = (N_NEU > 1) ? $clog2(N_NEU) : 1;

  sched_state_e state, state_nxt;

  logic [IDX_W-1:0]        idx;
  logic [N_IN*IN_W-1:0]    in_lat;
  logic [N_NEU*OUT_W-1:0]  slots;
  logic                    err_q;
  logic                    wait_clr, wait_en, wait_exp;
  logic                    accept, last, captured;
  logic [OUT_W-1:0]        res_clean;

  sched_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wait_clr),
    .enable  (wait_en),
    .expired (wait_exp)
  );

  assign accept   = (state == IDLE) && in_valid;
  assign captured = (state == WAIT) && nrn_done;
  assign last     = (idx == IDX_W'(N_NEU - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A result arriving on the timeout cycle still counts.
        if (nrn_done)      state_nxt = last ? DONE : ISSUE;
        else if (wait_exp) state_nxt = IDLE;
      end
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    nrn_start = (state == ISSUE);
    out_valid = (state == DONE);
    wait_clr  = (state == ISSUE);
    wait_en   = (state == WAIT) && !nrn_done;
  end

  always_comb begin
`ifdef HIDDEN_LAYER_SCHED_RELU_EN
    res_clean = relu(nrn_result);
`else
    res_clean = nrn_result;
`endif
  end

  always_comb begin
    nrn_w = '0;
    for (int j = 0; j < N_NEU; j++) begin
      if (idx == IDX_W'(j)) nrn_w = weights[j*N_IN*W_W +: N_IN*W_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      in_lat <= '0;
      slots  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        in_lat <= in_vec;
        idx    <= '0;
      end
      if (captured) begin
        for (int j = 0; j < N_NEU; j++) begin
          if (idx == IDX_W'(j)) slots[j*OUT_W +: OUT_W] <= res_clean;
        end
        if (!last) idx <= idx + IDX_W'(1);
      end
      if (wait_en && wait_exp) begin
        slots <= '0;
        err_q <= 1'b1;
      end
    end
  end

  assign nrn_in      = in_lat;
  assign out_vec     = slots;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_hidden_layer_scheduler.sv
// Scoreboard bench for hidden_layer_scheduler: a behavioural neuron answers each
// start after a chosen latency; expected out_vec is queued on accept.
module tb_hidden_layer_scheduler;

  localparam int IN_W = 5, W_W = 5, OUT_W = 12, N_IN = 4, N_NEU = 4, TO = 8;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [N_IN*IN_W-1:0]      in_vec;
  logic [N_NEU*N_IN*W_W-1:0] weights;
  logic                      nrn_start;
  logic [N_IN*IN_W-1:0]      nrn_in;
  logic [N_IN*W_W-1:0]       nrn_w;
  logic                      nrn_done;
  logic [OUT_W-1:0]          nrn_result;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_NEU*OUT_W-1:0]    out_vec;
  logic                      err_timeout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_hs = -100;
  logic [N_NEU*OUT_W-1:0] sb_q[$];

  hidden_layer_scheduler #(
    .IN_W(IN_W), .W_W(W_W), .OUT_W(OUT_W), .N_IN(N_IN), .N_NEU(N_NEU), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .weights(weights), .nrn_start(nrn_start), .nrn_in(nrn_in), .nrn_w(nrn_w),
    .nrn_done(nrn_done), .nrn_result(nrn_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expected, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OUT_W-1:0] model_slot(input logic [OUT_W-1:0] r);
`ifdef HIDDEN_LAYER_SCHED_RELU_EN
    return r[OUT_W-1] ? '0 : r;
`else
    return r;
`endif
  endfunction

  task automatic wait_start(output int s, output bit ok);
    for (int k = 0; k < 40 && !nrn_start; k++) step();
    ok = nrn_start;
    s  = cyc;
    if (!ok) check("start_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic run_job(input logic [N_IN*IN_W-1:0] vec,
                         input logic [OUT_W-1:0] r0, input logic [OUT_W-1:0] r1,
                         input logic [OUT_W-1:0] r2, input logic [OUT_W-1:0] r3,
                         input int lat, input int hold, input bit keep_valid);
    logic [OUT_W-1:0] res[4];
    logic [N_NEU*OUT_W-1:0] exp_vec, snap;
    int t0, s;
    bit ok;
    res = '{r0, r1, r2, r3};
    in_vec   = vec;
    in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    t0 = cyc;
    for (int j = 0; j < N_NEU; j++) exp_vec[j*OUT_W +: OUT_W] = model_slot(res[j]);
    sb_q.push_back(exp_vec);
    step();
    if (!keep_valid) in_valid = 1'b0;
    for (int j = 0; j < N_NEU; j++) begin
      wait_start(s, ok);
      if (!ok) return;
      check("start_cycle", 64'(s - t0), 64'(1 + j*(lat+1)));
      check("nrn_w", nrn_w, weights[j*N_IN*W_W +: N_IN*W_W]);
      check("nrn_in", nrn_in, vec);
      if (j == 0) check("in_ready_busy", in_ready, 0);
      step();
      check("start_pulse", nrn_start, 0);
      repeat (lat - 1) step();
      nrn_done   = 1'b1;
      nrn_result = res[j];
      step();
      nrn_done   = 1'b0;
      nrn_result = '0;
    end
    for (int k = 0; k < 40 && !out_valid; k++) step();
    check("out_valid_cycle", 64'(cyc - t0), 64'(1 + N_NEU*(lat+1)));
    if (!out_valid) return;
    snap = out_vec;
    repeat (hold) begin
      step();
      check("bp_valid", out_valid, 1);
      check("bp_vec", out_vec, snap);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    if (sb_q.size() == 0) check("sb_empty", 64'd0, 64'd1);
    else check("out_vec", out_vec, sb_q.pop_front());
    last_hs = cyc;
    step();
    out_ready = 1'b0;
    check("in_ready_after", in_ready, 1);
    check("out_valid_drop", out_valid, 0);
  endtask

  initial begin
    int s;
    bit ok;
    bit saw_valid;
    rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; nrn_done = 1'b0;
    nrn_result = '0; out_ready = 1'b0;
    for (int k = 0; k < N_NEU*N_IN; k++) weights[k*W_W +: W_W] = W_W'(k*3 - 11);
    step(); step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_nrn_start", nrn_start, 0);
    check("rst_err", err_timeout, 0);
    check("rst_out_vec", out_vec, 0);
    rst_n = 1'b1;
    step();

    // nominal L=2 with 5 cycles of backpressure
    run_job({5'd4, 5'd3, 5'd2, 5'd1}, 12'd10, 12'd20, 12'd30, 12'd40, 2, 5, 1'b0);
    // negative results: raw or clamped depending on build
    run_job({5'h1F, 5'h10, 5'd7, 5'd9}, 12'd5, 12'hFF9, 12'h800, 12'h7FF, 1, 0, 1'b0);
    // back-to-back with in_valid held across both jobs
    run_job({5'd1, 5'd1, 5'd2, 5'd3}, 12'd100, 12'hF00, 12'd7, 12'd8, 3, 1, 1'b1);
    check("b2b_accept_gap", 64'(cyc - last_hs), 64'd1);
    run_job({5'd6, 5'd5, 5'd4, 5'd3}, 12'd1, 12'd2, 12'd3, 12'd4, 1, 0, 1'b0);
    // done on the last permitted wait cycle wins over timeout
    run_job({5'd2, 5'd2, 5'd2, 5'd2}, 12'h123, 12'h456, 12'h0, 12'h789, TO, 0, 1'b0);
    check("boundary_no_err", err_timeout, 0);

    // timeout: neuron never answers
    in_vec = {5'd9, 5'd8, 5'd7, 5'd6};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_start(s, ok);
    saw_valid = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      step();
      if (out_valid) saw_valid = 1'b1;
    end
    check("to_err_before", err_timeout, 0);
    check("to_busy_before", in_ready, 0);
    step();
    if (out_valid) saw_valid = 1'b1;
    check("to_err_set", err_timeout, 1);
    check("to_idle", in_ready, 1);
    check("to_out_vec", out_vec, 0);
    check("to_no_valid", saw_valid, 0);
    run_job({5'd3, 5'd3, 5'd3, 5'd3}, 12'd11, 12'd22, 12'd33, 12'd44, 2, 0, 1'b0);
    check("err_sticky", err_timeout, 1);

    // reset during WAIT of idx 2, then a late done
    in_vec = {5'd1, 5'd2, 5'd3, 5'd4};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      wait_start(s, ok);
      step(); step();
      nrn_done = 1'b1; nrn_result = 12'd77;
      step();
      nrn_done = 1'b0; nrn_result = '0;
    end
    wait_start(s, ok);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_vec", out_vec, 0);
    check("mrst_err", err_timeout, 0);
    nrn_done = 1'b1; nrn_result = 12'd55;
    step();
    nrn_done = 1'b0; nrn_result = '0;
    check("late_done_vec", out_vec, 0);
    check("late_done_idle", in_ready, 1);
    check("late_done_valid", out_valid, 0);
    check("late_done_start", nrn_start, 0);
    run_job({5'd5, 5'd6, 5'd7, 5'd8}, 12'hABC, 12'd1, 12'hFFF, 12'd3, 2, 2, 1'b0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
